// File: rtl/wt_sched_pkg.sv
// Shared types and default constants for the weight-buffer scheduler.
//   buf_state_e : per-buffer lifecycle state (FREE, FILL, READY, DRAIN)
//   *_D         : default parameter values for weight_buf_sched
//   wt_beat_t   : one weight beat at the default width
package wt_sched_pkg;

  localparam int DATA_WIDTH_D   = 24;
  localparam int DEPTH_D        = 4096;
  localparam int TILE_ENTRIES_D = 8;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } buf_state_e;

  typedef logic [DATA_WIDTH_D-1:0] wt_beat_t;

endpackage

// File: rtl/weight_buf_sched_rr_arb2.sv
// Two-requester round-robin arbiter for the shared FIFO buffer-select line.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   req_fill, req_drain    requests from the fill and drain streams
//   gnt_fill, gnt_drain    one-hot (or zero) grants, combinational
// Only contested cycles move the priority; the loser of a contested cycle
// wins the next one. Drain is favoured out of reset.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_fill,
  input  logic req_drain,
  output logic gnt_fill,
  output logic gnt_drain
);

  logic favor_fill_q;

  assign gnt_fill  = req_fill  && (!req_drain || favor_fill_q);
  assign gnt_drain = req_drain && (!req_fill  || !favor_fill_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favor_fill_q <= 1'b0;
    end else if (req_fill && req_drain) begin
      favor_fill_q <= ~favor_fill_q;
    end
  end

endmodule

// File: rtl/weight_buf_sched.sv
// Double-buffered weight FIFO scheduler. Accepts tile-load commands, steers
// DMA beats into a free buffer, and drains the oldest filled buffer to the
// systolic array, arbitrating the single FIFO buffer-select line per cycle.
// Ports:
//   cmd_*         load-command handshake, tile count, reject pulse
//   dma_*         DMA beat stream in (dma_ready = fill grant)
//   arr_rd_*      array read request/grant and 1-cycle-latency read data
//   fifo_*        weight FIFO control (this block is the sole driver)
//   perf_*        stall counters, present only when WT_SCHED_PERF_EN is defined
//
// Buffer state | meaning
// FREE         | empty, can take a new command
// FILL         | receiving DMA beats until cnt == tgt
// READY        | fully written, waiting to be drained
// DRAIN        | at least one beat read out, until cnt == tgt
module weight_buf_sched
  import wt_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int DEPTH        = DEPTH_D,
  parameter int TILE_ENTRIES = TILE_ENTRIES_D,
  parameter int CNT_W        = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_num_tiles,
  output logic                  cmd_err,
  input  logic                  dma_valid,
  output logic                  dma_ready,
  input  logic [DATA_WIDTH-1:0] dma_data,
  input  logic                  arr_rd_req,
  output logic                  arr_rd_gnt,
  output logic                  arr_rd_valid,
  output logic [DATA_WIDTH-1:0] arr_rd_data,
  output logic                  arr_rd_last,
  output logic                  fifo_wt_buf_sel,
  output logic [7:0]            fifo_wt_num_tiles,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_wr_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty
`ifdef WT_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_fill_stall,
  output logic [31:0]           perf_drain_stall
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  buf_state_e       state_q [2];
  buf_state_e       state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [CNT_W-1:0] tgt_q   [2];
  logic [CNT_W-1:0] tgt_d   [2];
  logic             oldest_q, oldest_d;
  logic             sel_q;

  logic [1:0]       is_free, is_fill;
  logic             fill_active, fill_idx, free_idx;
  logic             cmd_fire, cmd_bad, cmd_ok;
  logic [CNT_W-1:0] n_tgt;
  logic             drain_cand;
  logic             fill_req, drain_req, fill_gnt, drain_gnt;
  logic [CNT_W-1:0] fill_cnt_nxt, drain_cnt_nxt;
  logic             fill_done, drain_done;

  always_comb begin
    is_free = '0;
    is_fill = '0;
    for (int b = 0; b < 2; b++) begin
      is_free[b] = (state_q[b] == FREE);
      is_fill[b] = (state_q[b] == FILL);
    end
  end

  // At most one buffer is ever in FILL because commands wait for it to finish.
  assign fill_active = |is_fill;
  assign fill_idx    = is_fill[1];
  assign free_idx    = ~is_free[0];

  assign cmd_ready = (|is_free) && !fill_active;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign n_tgt     = CNT_W'(cmd_num_tiles) * CNT_W'(TILE_ENTRIES);
  assign cmd_bad   = (n_tgt == '0) || (n_tgt > DEPTH_C);
  assign cmd_ok    = cmd_fire && !cmd_bad;

  assign drain_cand = (state_q[oldest_q] == READY) || (state_q[oldest_q] == DRAIN);
  assign fill_req   = fill_active && dma_valid;
  assign drain_req  = drain_cand && arr_rd_req;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_fill  (fill_req),
    .req_drain (drain_req),
    .gnt_fill  (fill_gnt),
    .gnt_drain (drain_gnt)
  );

  assign fill_cnt_nxt  = cnt_q[fill_idx] + 1'b1;
  assign fill_done     = (fill_cnt_nxt == tgt_q[fill_idx]);
  assign drain_cnt_nxt = cnt_q[oldest_q] + 1'b1;
  assign drain_done    = (drain_cnt_nxt == tgt_q[oldest_q]);

  assign dma_ready       = fill_gnt;
  assign fifo_wr_en      = fill_gnt;
  assign fifo_wr_data    = dma_data;
  assign arr_rd_gnt      = drain_gnt;
  assign fifo_rd_en      = drain_gnt;
  assign fifo_wt_buf_sel = fill_gnt ? fill_idx : (drain_gnt ? oldest_q : sel_q);
  assign arr_rd_data     = arr_rd_valid ? fifo_rd_data : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    oldest_d = oldest_q;

    if (cmd_ok) begin
      state_d[free_idx] = FILL;
      tgt_d[free_idx]   = n_tgt;
      cnt_d[free_idx]   = '0;
      // With nothing in flight the oldest pointer may point at either buffer;
      // re-anchor it so the first buffer filled is the first one drained.
      if (&is_free) oldest_d = free_idx;
    end

    if (fill_gnt) begin
      if (fill_done) begin
        state_d[fill_idx] = READY;
        cnt_d[fill_idx]   = '0;
      end else begin
        cnt_d[fill_idx]   = fill_cnt_nxt;
      end
    end

    if (drain_gnt) begin
      if (drain_done) begin
        state_d[oldest_q] = FREE;
        cnt_d[oldest_q]   = '0;
        oldest_d          = ~oldest_q;
      end else begin
        state_d[oldest_q] = DRAIN;
        cnt_d[oldest_q]   = drain_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= FREE;
        cnt_q[b]   <= '0;
        tgt_q[b]   <= '0;
      end
      oldest_q          <= 1'b0;
      sel_q             <= 1'b0;
      cmd_err           <= 1'b0;
      fifo_wt_num_tiles <= '0;
      arr_rd_valid      <= 1'b0;
      arr_rd_last       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      oldest_q     <= oldest_d;
      sel_q        <= fifo_wt_buf_sel;
      cmd_err      <= cmd_fire && cmd_bad;
      arr_rd_valid <= drain_gnt;
      arr_rd_last  <= drain_gnt && drain_done;
      if (cmd_ok) fifo_wt_num_tiles <= cmd_num_tiles;
    end
  end

`ifdef WT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fill_stall  <= '0;
      perf_drain_stall <= '0;
    end else begin
      if (((fill_req && !fill_gnt) || (dma_valid && !fill_active)) && (perf_fill_stall != '1))
        perf_fill_stall <= perf_fill_stall + 1'b1;
      if (arr_rd_req && !drain_gnt && (perf_drain_stall != '1))
        perf_drain_stall <= perf_drain_stall + 1'b1;
    end
  end
`endif

  // Occupancy is tracked by the counters; the FIFO flags only cross-check it.
  a_no_wr_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr_en && fifo_wr_full));
  a_no_rd_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_rd_empty));

endmodule

// File: tb/tb_weight_buf_sched.sv
module tb_weight_buf_sched;
  import wt_sched_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_err;
  logic [7:0] cmd_num_tiles;
  logic       dma_valid, dma_ready;
  wt_beat_t   dma_data;
  logic       arr_rd_req, arr_rd_gnt, arr_rd_valid, arr_rd_last;
  wt_beat_t   arr_rd_data;
  logic       fifo_wt_buf_sel;
  logic [7:0] fifo_wt_num_tiles;
  logic       fifo_wr_en, fifo_rd_en;
  wt_beat_t   fifo_wr_data, fifo_rd_data;
  logic       fifo_wr_full, fifo_rd_empty;

  // second instance with 32-entry tiles, used for the oversize-command check
  logic       b_cmd_valid, b_cmd_ready, b_cmd_err;
  logic [7:0] b_cmd_num_tiles;
  logic       b_dma_ready, b_gnt, b_val, b_last, b_sel, b_wr_en, b_rd_en;
  logic [7:0] b_num_tiles;
  wt_beat_t   b_rd_data, b_wr_data;

`ifdef WT_SCHED_PERF_EN
  logic [31:0] perf_fill_stall, perf_drain_stall, b_pf, b_pd;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  weight_buf_sched u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_tiles(cmd_num_tiles), .cmd_err(cmd_err),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_data(dma_data),
    .arr_rd_req(arr_rd_req), .arr_rd_gnt(arr_rd_gnt), .arr_rd_valid(arr_rd_valid),
    .arr_rd_data(arr_rd_data), .arr_rd_last(arr_rd_last),
    .fifo_wt_buf_sel(fifo_wt_buf_sel), .fifo_wt_num_tiles(fifo_wt_num_tiles),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty)
`ifdef WT_SCHED_PERF_EN
    , .perf_fill_stall(perf_fill_stall), .perf_drain_stall(perf_drain_stall)
`endif
  );

  weight_buf_sched #(.TILE_ENTRIES(32)) u_big (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_num_tiles(b_cmd_num_tiles), .cmd_err(b_cmd_err),
    .dma_valid(1'b0), .dma_ready(b_dma_ready), .dma_data('0),
    .arr_rd_req(1'b0), .arr_rd_gnt(b_gnt), .arr_rd_valid(b_val),
    .arr_rd_data(b_rd_data), .arr_rd_last(b_last),
    .fifo_wt_buf_sel(b_sel), .fifo_wt_num_tiles(b_num_tiles),
    .fifo_wr_en(b_wr_en), .fifo_wr_data(b_wr_data), .fifo_wr_full(1'b0),
    .fifo_rd_en(b_rd_en), .fifo_rd_data('0), .fifo_rd_empty(1'b0)
`ifdef WT_SCHED_PERF_EN
    , .perf_fill_stall(b_pf), .perf_drain_stall(b_pd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural weight FIFO: one queue per buffer, read data one cycle after rd_en
  wt_beat_t q0[$];
  wt_beat_t q1[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      fifo_rd_data <= '0;
    end else begin
      if (fifo_wr_en) begin
        if (fifo_wt_buf_sel) q1.push_back(fifo_wr_data);
        else                 q0.push_back(fifo_wr_data);
      end
      if (fifo_rd_en) begin
        if (fifo_wt_buf_sel && q1.size() > 0)       fifo_rd_data <= q1.pop_front();
        else if (!fifo_wt_buf_sel && q0.size() > 0) fifo_rd_data <= q0.pop_front();
        else                                        fifo_rd_data <= 24'hBADBAD;
      end
    end
  end

  typedef struct {
    logic       cv;
    logic [7:0] nt;
    logic       dv;
    wt_beat_t   dd;
    logic       rq;
    logic       e_rdy;
    logic       e_dmar;
    logic       e_gnt;
    logic       e_sel;
    logic       e_val;
    logic       e_last;
    wt_beat_t   e_data;
    logic       e_err;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(logic cv, logic [7:0] nt, logic dv, wt_beat_t dd, logic rq,
                              logic rdy, logic dmar, logic gnt, logic sel, logic val,
                              logic last, wt_beat_t data, logic err);
    vec_t v;
    v.cv = cv; v.nt = nt; v.dv = dv; v.dd = dd; v.rq = rq;
    v.e_rdy = rdy; v.e_dmar = dmar; v.e_gnt = gnt; v.e_sel = sel;
    v.e_val = val; v.e_last = last; v.e_data = data; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0; cmd_num_tiles = '0; dma_valid = 1'b0; dma_data = '0; arr_rd_req = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_num_tiles = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic issue_cmd(input logic [7:0] nt);
    cmd_valid = 1'b1; cmd_num_tiles = nt;
    @(negedge clk);
    chk("cmd_ready at issue", cmd_ready, 1);
    next_cyc();
    cmd_valid = 1'b0; cmd_num_tiles = '0;
  endtask

  task automatic fill(input int n, input wt_beat_t base, input logic sel);
    for (int i = 0; i < n; i++) begin
      dma_valid = 1'b1; dma_data = base + wt_beat_t'(i);
      @(negedge clk);
      chk($sformatf("fill dma_ready %0d", i), dma_ready, 1);
      chk($sformatf("fill buf_sel %0d", i), fifo_wt_buf_sel, sel);
      chk($sformatf("fill wr_en %0d", i), fifo_wr_en, 1);
      next_cyc();
    end
    dma_valid = 1'b0;
  endtask

  initial begin
    int fcnt;
    rst_n = 1'b0;
    idle_in();
    fifo_wr_full = 1'b0;
    fifo_rd_empty = 1'b0;

    tbl[0] = mk(0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 1);
    tbl[3] = mk(1, 1, 1, 'hAA, 1,    1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      tbl[4+k] = mk(0, 0, 1, 'h100 + k, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 1, 'h107, 1,  0, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1,      1, 0, 1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 7; j++)
      tbl[13+j] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 'h100 + j, 0);
    tbl[20] = mk(0, 0, 0, 0, 0,      1, 0, 0, 0, 1, 1, 'h107, 0);
    tbl[21] = mk(0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0, 0);

    #2;
    chk("in-reset cmd_ready", cmd_ready, 1);
    chk("in-reset num_tiles", fifo_wt_num_tiles, 0);
    do_reset();

    // table: reject, accept, fill with blocked command, drain with last
    for (int i = 0; i < 22; i++) begin
      cmd_valid = tbl[i].cv; cmd_num_tiles = tbl[i].nt;
      dma_valid = tbl[i].dv; dma_data = tbl[i].dd; arr_rd_req = tbl[i].rq;
      @(negedge clk);
      chk($sformatf("tbl%0d cmd_ready", i), cmd_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d dma_ready", i), dma_ready, tbl[i].e_dmar);
      chk($sformatf("tbl%0d arr_rd_gnt", i), arr_rd_gnt, tbl[i].e_gnt);
      chk($sformatf("tbl%0d buf_sel", i), fifo_wt_buf_sel, tbl[i].e_sel);
      chk($sformatf("tbl%0d rd_valid", i), arr_rd_valid, tbl[i].e_val);
      chk($sformatf("tbl%0d rd_last", i), arr_rd_last, tbl[i].e_last);
      chk($sformatf("tbl%0d rd_data", i), arr_rd_data, tbl[i].e_data);
      chk($sformatf("tbl%0d cmd_err", i), cmd_err, tbl[i].e_err);
      next_cyc();
    end
    idle_in();

    // 2 tiles: 16 beats into buffer 0, then 16 in-order reads
    issue_cmd(2);
    chk("B num_tiles", fifo_wt_num_tiles, 2);
    fill(16, 24'hA00000, 1'b0);
    for (int k = 0; k <= 16; k++) begin
      arr_rd_req = (k < 16);
      @(negedge clk);
      chk($sformatf("B gnt %0d", k), arr_rd_gnt, (k < 16));
      if (k < 16) chk($sformatf("B sel %0d", k), fifo_wt_buf_sel, 0);
      if (k > 0) begin
        chk($sformatf("B valid %0d", k), arr_rd_valid, 1);
        chk($sformatf("B data %0d", k), arr_rd_data, 24'hA00000 + k - 1);
        chk($sformatf("B last %0d", k), arr_rd_last, (k == 16));
      end
      next_cyc();
    end
    arr_rd_req = 1'b0;
    @(negedge clk);
    chk("B valid after", arr_rd_valid, 0);
    chk("B cmd_ready after", cmd_ready, 1);
    next_cyc();

    // two commands, both buffers READY, drain order 0 then 1
    issue_cmd(1);
    fill(8, 24'hC000, 1'b0);
    issue_cmd(1);
    fill(8, 24'hC100, 1'b1);
    @(negedge clk);
    chk("C both ready cmd_ready", cmd_ready, 0);
    next_cyc();
    for (int k = 0; k <= 16; k++) begin
      arr_rd_req = (k < 16);
      @(negedge clk);
      chk($sformatf("C gnt %0d", k), arr_rd_gnt, (k < 16));
      if (k < 16) chk($sformatf("C sel %0d", k), fifo_wt_buf_sel, (k >= 8));
      if (k > 0) begin
        chk($sformatf("C valid %0d", k), arr_rd_valid, 1);
        chk($sformatf("C data %0d", k), arr_rd_data,
            (k - 1 < 8) ? 24'hC000 + k - 1 : 24'hC100 + k - 9);
      end
      chk($sformatf("C last %0d", k), arr_rd_last, (k == 8 || k == 16));
      chk($sformatf("C cmd_ready %0d", k), cmd_ready, (k >= 8));
      next_cyc();
    end
    arr_rd_req = 1'b0;

    // contested fill/drain: alternate every cycle, drain first after reset
    do_reset();
    issue_cmd(1);
    fill(8, 24'hD000, 1'b0);
    issue_cmd(1);
    fcnt = 0;
    for (int k = 0; k < 16; k++) begin
      arr_rd_req = 1'b1; dma_valid = 1'b1; dma_data = 24'hD100 + fcnt;
      @(negedge clk);
      chk($sformatf("D gnt %0d", k), arr_rd_gnt, (k % 2 == 0));
      chk($sformatf("D dma_ready %0d", k), dma_ready, (k % 2 == 1));
      chk($sformatf("D sel %0d", k), fifo_wt_buf_sel, (k % 2 == 1));
      chk($sformatf("D cmd_ready %0d", k), cmd_ready, 0);
      if (k % 2 == 1) begin
        chk($sformatf("D valid %0d", k), arr_rd_valid, 1);
        chk($sformatf("D data %0d", k), arr_rd_data, 24'hD000 + (k - 1) / 2);
        chk($sformatf("D last %0d", k), arr_rd_last, (k == 15));
      end
      if (dma_ready) fcnt++;
      next_cyc();
    end
    dma_valid = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      arr_rd_req = (k < 8);
      @(negedge clk);
      chk($sformatf("D2 gnt %0d", k), arr_rd_gnt, (k < 8));
      if (k < 8) chk($sformatf("D2 sel %0d", k), fifo_wt_buf_sel, 1);
      if (k == 0) chk("D2 cmd_ready", cmd_ready, 1);
      if (k > 0) begin
        chk($sformatf("D2 valid %0d", k), arr_rd_valid, 1);
        chk($sformatf("D2 data %0d", k), arr_rd_data, 24'hD100 + k - 1);
        chk($sformatf("D2 last %0d", k), arr_rd_last, (k == 8));
      end
      next_cyc();
    end
    arr_rd_req = 1'b0;

    // asynchronous reset in the middle of a fill
    do_reset();
    issue_cmd(1);
    fill(5, 24'hE000, 1'b0);
    dma_valid = 1'b1; dma_data = 24'hE005; arr_rd_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("E rst cmd_ready", cmd_ready, 1);
    chk("E rst dma_ready", dma_ready, 0);
    chk("E rst wr_en", fifo_wr_en, 0);
    chk("E rst rd_en", fifo_rd_en, 0);
    chk("E rst buf_sel", fifo_wt_buf_sel, 0);
    chk("E rst num_tiles", fifo_wt_num_tiles, 0);
    chk("E rst cmd_err", cmd_err, 0);
    chk("E rst rd_valid", arr_rd_valid, 0);
    chk("E rst rd_last", arr_rd_last, 0);
    chk("E rst rd_data", arr_rd_data, 0);
    idle_in();
    next_cyc();
    rst_n = 1'b1;
    issue_cmd(3);
    chk("E num_tiles after", fifo_wt_num_tiles, 3);
    fill(1, 24'hE100, 1'b0);

    // 255 tiles = 2040 entries, accepted
    do_reset();
    issue_cmd(255);
    @(negedge clk);
    chk("F255 cmd_err", cmd_err, 0);
    chk("F255 cmd_ready", cmd_ready, 0);
    chk("F255 num_tiles", fifo_wt_num_tiles, 255);
    next_cyc();

    // 32-entry tiles: 200 tiles oversize, 0 tiles empty, 128 tiles exactly DEPTH
    b_cmd_valid = 1'b1; b_cmd_num_tiles = 200;
    @(negedge clk); chk("G200 ready", b_cmd_ready, 1); next_cyc();
    b_cmd_valid = 1'b0;
    @(negedge clk); chk("G200 err", b_cmd_err, 1); chk("G200 ready after", b_cmd_ready, 1); next_cyc();
    b_cmd_valid = 1'b1; b_cmd_num_tiles = 0;
    @(negedge clk); chk("G err pulse end", b_cmd_err, 0); next_cyc();
    b_cmd_valid = 1'b0;
    @(negedge clk); chk("G0 err", b_cmd_err, 1); chk("G0 num_tiles", b_num_tiles, 0); next_cyc();
    b_cmd_valid = 1'b1; b_cmd_num_tiles = 128;
    @(negedge clk); chk("G128 ready", b_cmd_ready, 1); next_cyc();
    b_cmd_valid = 1'b0;
    @(negedge clk);
    chk("G128 err", b_cmd_err, 0);
    chk("G128 ready after", b_cmd_ready, 0);
    chk("G128 num_tiles", b_num_tiles, 128);
    next_cyc();

`ifdef WT_SCHED_PERF_EN
    do_reset();
    @(negedge clk);
    chk("P drain init", perf_drain_stall, 0);
    chk("P fill init", perf_fill_stall, 0);
    next_cyc();
    for (int k = 0; k < 10; k++) begin
      arr_rd_req = 1'b1;
      dma_valid = (k < 4);
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    chk("P drain stall", perf_drain_stall, 10);
    chk("P fill stall", perf_fill_stall, 4);
    next_cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_buf_sched.md
# weight_buf_sched

Scheduler for the double-buffered weight FIFO. It accepts tile-load commands and steers DMA beats into a free weight buffer. It also serves per-beat read requests from the systolic array out of the oldest filled buffer. The FIFO has one shared buffer-select line, so this block arbitrates it cycle by cycle between the fill stream and the drain stream. The block sits between the DMA engine, the systolic-array weight loader and the weight FIFO, and it is the only driver of the FIFO control pins.

## Interface
Parameters:
- DATA_WIDTH, 24, weight beat width; must match the FIFO.
- DEPTH, 4096, entries per FIFO buffer.
- TILE_ENTRIES, 8, FIFO entries per weight tile.
- CNT_W, 13, width of the per-load entry counters; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  load-command valid.
- cmd_ready  out  1  high when a FREE buffer exists and no buffer is FILL.
- cmd_num_tiles  in  8  number of tiles in the command.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- dma_valid  in  1  DMA beat valid.
- dma_ready  out  1  DMA beat accepted this cycle (fill grant).
- dma_data  in  DATA_WIDTH  DMA beat payload.
- arr_rd_req  in  1  array requests one weight beat.
- arr_rd_gnt  out  1  read request accepted this cycle (drain grant).
- arr_rd_valid  out  1  arr_rd_data is valid this cycle.
- arr_rd_data  out  DATA_WIDTH  weight beat to the array.
- arr_rd_last  out  1  marks the final beat of a buffer; aligned with arr_rd_valid.
- fifo_wt_buf_sel  out  1  FIFO buffer select.
- fifo_wt_num_tiles  out  8  tile count of the command currently filling.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- fifo_wr_full  in  1  FIFO full flag; used only by the checker.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- fifo_rd_empty  in  1  FIFO empty flag; used only by the checker.

## Operation
- Each buffer b∈{0,1} has a state FREE→FILL→READY→DRAIN→FREE, a target count tgt[b] and a beat count cnt[b].
- Command acceptance, on cmd_valid&&cmd_ready:
  - The target is N = cmd_num_tiles*TILE_ENTRIES, computed at CNT_W bits.
  - If N==0 or N>DEPTH, the command is dropped and cmd_err pulses. No state changes.
  - Otherwise the lowest-index FREE buffer goes to FILL with tgt=N, cnt=0.
- Drain order follows fill order through a 1-bit oldest pointer. A buffer that is READY and oldest is the drain candidate.
- Fill request: a buffer is in FILL and dma_valid is high.
- Drain request: the candidate buffer is READY or DRAIN, that buffer is the oldest, and arr_rd_req is high.
- Arbitration:
  - Only one request present: it wins.
  - Both present: the winner is the loser of the last contested cycle (round-robin). After reset, drain is favoured.
- Fill grant:
  - dma_ready=1, fifo_wr_en=1, fifo_wr_data=dma_data, fifo_wt_buf_sel = fill buffer.
  - cnt increments. When cnt reaches tgt, the buffer goes FILL→READY.
- Drain grant:
  - arr_rd_gnt=1, fifo_rd_en=1, fifo_wt_buf_sel = drain buffer.
  - A READY buffer goes to DRAIN and cnt increments.
  - When cnt reaches tgt, the buffer goes to FREE and the oldest pointer toggles.
- Idle cycles: fifo_wt_buf_sel holds its last value.
- fifo_wr_full or fifo_rd_empty asserted on a granted beat is a protocol error and is flagged by an assertion only. Occupancy is guaranteed by the counters.

## Timing
- Reset values:
  - All buffers FREE, oldest=0, round-robin favours drain.
  - cmd_ready=1, cmd_err=0, dma_ready=0, arr_rd_gnt=0, arr_rd_valid=0, arr_rd_last=0, arr_rd_data=0.
  - fifo_wr_en=0, fifo_rd_en=0, fifo_wt_buf_sel=0, fifo_wt_num_tiles=0.
- Combinational outputs, from registered state plus current requests: dma_ready, arr_rd_gnt, fifo_wr_en, fifo_rd_en, fifo_wt_buf_sel, fifo_wr_data.
- No path runs from fifo_wr_full or fifo_rd_empty to any output.
- Read latency is 1 cycle:
  - arr_rd_valid is a registered copy of the drain grant.
  - arr_rd_data = fifo_rd_data in that cycle.
  - arr_rd_last is registered and set when the grant is the tgt-th beat.
- A command accepted in cycle t allows a fill grant from t+1.
- The FILL→READY edge in cycle t allows a drain grant from t+1.
- Simultaneous events:
  - A buffer going DRAIN→FREE makes cmd_ready=1 in the next cycle, not the same one.
  - The last fill beat and a command in the same cycle: cmd_ready stays 0 until the buffer is READY.
- Asynchronous reset in mid-operation aborts everything to reset values. The FIFO shares rst_n.

## Configuration
- WT_SCHED_PERF_EN:
  - Defined: adds outputs perf_fill_stall and perf_drain_stall, 32 bits each, reset 0 and saturating.
  - perf_fill_stall counts cycles where a fill request lost arbitration or dma_valid was high with no FILL buffer.
  - perf_drain_stall counts cycles where arr_rd_req was high with no drain grant.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- Package wt_sched_pkg holds:
  - buf_state_e (FREE, FILL, READY, DRAIN; 2 bits).
  - Default constants DATA_WIDTH_D, DEPTH_D, TILE_ENTRIES_D.
  - Typedef wt_beat_t.
- One sub-module, rr_arb2: a 2-requester round-robin arbiter with a registered last-winner flag.

## Test plan
- cmd 2 tiles, then 16 DMA beats A0..A15, then 16 arr_rd_req → 16 writes to buffer 0 and 16 reads in order. arr_rd_last on A15; cmd_ready=1 one cycle later.
- Two commands of 1 tile each → buffers 0 then 1. Drain order 0 then 1 even when buffer 1 is READY first is impossible, because it is filled after buffer 0.
- Continuous dma_valid and arr_rd_req with a FILL buffer and a READY buffer → grants alternate every cycle. fifo_wt_buf_sel toggles accordingly and no beat is lost.
- cmd_num_tiles=0 and cmd_num_tiles=255 (2040≤4096, accepted), then a command giving N>DEPTH with TILE_ENTRIES=32 → the 0 and oversized commands pulse cmd_err with no state change.
- rst_n asserted mid-fill at beat 5 → all outputs at reset values immediately. After release, a new cmd is accepted into buffer 0.
- WT_SCHED_PERF_EN defined, arr_rd_req held 10 cycles with no READY buffer → perf_drain_stall=10.
